// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipeline registers, PC and operand forwarding for the five-stage core
// Optional saturating stall/flush counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              StallF,
   input  logic              StallD,
   input  logic              FlushD,
   input  logic              FlushE,
   input  logic [1:0]        FowardAE,
   input  logic [1:0]        FowardBE,
   input  logic [31:0]       InstrF,
   input  logic [ADDR_W-1:0] RA1D,
   input  logic [ADDR_W-1:0] RA2D,
   input  logic [ADDR_W-1:0] WA3D,
   input  logic              RegWriteD,
   input  logic              MemToRegD,
   input  logic              MemWriteD,
   input  logic              PCSrcD,
   input  logic              BranchD,
   input  logic [DATA_W-1:0] RD1D,
   input  logic [DATA_W-1:0] RD2D,
   input  logic [DATA_W-1:0] ExtImmD,
   input  logic [DATA_W-1:0] ALUResultE,
   input  logic              CondExE,
   input  logic [DATA_W-1:0] ReadDataM,
   output logic [DATA_W-1:0] PCF,
   output logic [DATA_W-1:0] PCPlus4D,
   output logic [31:0]       InstrD,
   output logic [ADDR_W-1:0] RA1E,
   output logic [ADDR_W-1:0] RA2E,
   output logic [ADDR_W-1:0] WA3E,
   output logic [ADDR_W-1:0] WA3M,
   output logic [ADDR_W-1:0] WA3W,
   output logic              MemToRegE,
   output logic              PCSrcE,
   output logic              PCSrcM,
   output logic              PCSrcW,
   output logic              RegWriteM,
   output logic              RegWriteW,
   output logic              BranchTakenE,
   output logic [DATA_W-1:0] SrcAE,
   output logic [DATA_W-1:0] SrcBE,
   output logic [DATA_W-1:0] ExtImmE,
   output logic [DATA_W-1:0] ALUOutM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [DATA_W-1:0] ResultW,
   output logic              MemWriteM,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  FlushCount
);

   logic [DATA_W-1:0] pc_plus4;
   logic [DATA_W-1:0] pc_next;

   logic              reg_write_e;
   logic              mem_write_e;
   logic              branch_e;
   logic [DATA_W-1:0] rd1_e;
   logic [DATA_W-1:0] rd2_e;

   logic              reg_write_e_q;
   logic              mem_write_e_q;
   logic              pc_src_e_q;

   logic              mem_to_reg_m;
   logic              mem_to_reg_w;
   logic [DATA_W-1:0] alu_out_w;
   logic [DATA_W-1:0] read_data_w;

   assign pc_plus4 = PCF + DATA_W'(4);

   // A write-back PC update outranks a taken branch in Execute.
   always_comb begin
      pc_next = pc_plus4;
      if (PCSrcW)
         pc_next = ResultW;
      else if (BranchTakenE)
         pc_next = ALUResultE;
   end

   always_ff @(posedge CLK) begin
      if (!Reset)
         PCF <= '0;
      else if (!StallF)
         PCF <= pc_next;
   end

   always_ff @(posedge CLK) begin
      if (!Reset || FlushD) begin
         InstrD   <= '0;
         PCPlus4D <= '0;
      end else if (!StallD) begin
         InstrD   <= InstrF;
         PCPlus4D <= pc_plus4;
      end
   end

   // A flush turns the Execute slot into a bubble; operand data may pass through harmlessly.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         rd1_e   <= '0;
         rd2_e   <= '0;
         ExtImmE <= '0;
      end else begin
         rd1_e   <= RD1D;
         rd2_e   <= RD2D;
         ExtImmE <= ExtImmD;
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset || FlushE) begin
         RA1E        <= '0;
         RA2E        <= '0;
         WA3E        <= '0;
         reg_write_e <= 1'b0;
         MemToRegE   <= 1'b0;
         mem_write_e <= 1'b0;
         PCSrcE      <= 1'b0;
         branch_e    <= 1'b0;
      end else begin
         RA1E        <= RA1D;
         RA2E        <= RA2D;
         WA3E        <= WA3D;
         reg_write_e <= RegWriteD;
         MemToRegE   <= MemToRegD;
         mem_write_e <= MemWriteD;
         PCSrcE      <= PCSrcD;
         branch_e    <= BranchD;
      end
   end

   assign reg_write_e_q = reg_write_e & CondExE;
   assign mem_write_e_q = mem_write_e & CondExE;
   assign pc_src_e_q    = PCSrcE & CondExE;
   assign BranchTakenE  = branch_e & CondExE;

   always_comb begin
      SrcAE = rd1_e;
      case (FowardAE)
         2'b01:   SrcAE = ResultW;
         2'b10:   SrcAE = ALUOutM;
         default: SrcAE = rd1_e;
      endcase
   end

   always_comb begin
      SrcBE = rd2_e;
      case (FowardBE)
         2'b01:   SrcBE = ResultW;
         2'b10:   SrcBE = ALUOutM;
         default: SrcBE = rd2_e;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         WA3M         <= '0;
         RegWriteM    <= 1'b0;
         MemWriteM    <= 1'b0;
         mem_to_reg_m <= 1'b0;
         PCSrcM       <= 1'b0;
         ALUOutM      <= '0;
         WriteDataM   <= '0;
      end else begin
         WA3M         <= WA3E;
         RegWriteM    <= reg_write_e_q;
         MemWriteM    <= mem_write_e_q;
         mem_to_reg_m <= MemToRegE;
         PCSrcM       <= pc_src_e_q;
         ALUOutM      <= ALUResultE;
         WriteDataM   <= SrcBE;
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         WA3W         <= '0;
         RegWriteW    <= 1'b0;
         mem_to_reg_w <= 1'b0;
         PCSrcW       <= 1'b0;
         alu_out_w    <= '0;
         read_data_w  <= '0;
      end else begin
         WA3W         <= WA3M;
         RegWriteW    <= RegWriteM;
         mem_to_reg_w <= mem_to_reg_m;
         PCSrcW       <= PCSrcM;
         alu_out_w    <= ALUOutM;
         read_data_w  <= ReadDataM;
      end
   end

   assign ResultW = mem_to_reg_w ? read_data_w : alu_out_w;

`ifdef CTRL_PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (StallD && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (FlushE && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign StallCount = stall_cnt;
   assign FlushCount = flush_cnt;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe with directed vectors
module tb_ctrl_pipe;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 2;

   logic          CLK = 1'b0;
   logic          Reset;
   logic          StallF, StallD, FlushD, FlushE;
   logic [1:0]    FowardAE, FowardBE;
   logic [31:0]   InstrF;
   logic [AW-1:0] RA1D, RA2D, WA3D;
   logic          RegWriteD, MemToRegD, MemWriteD, PCSrcD, BranchD;
   logic [DW-1:0] RD1D, RD2D, ExtImmD, ALUResultE, ReadDataM;
   logic          CondExE;
   logic [DW-1:0] PCF, PCPlus4D;
   logic [31:0]   InstrD;
   logic [AW-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
   logic          MemToRegE, PCSrcE, PCSrcM, PCSrcW, RegWriteM, RegWriteW, BranchTakenE;
   logic [DW-1:0] SrcAE, SrcBE, ExtImmE, ALUOutM, WriteDataM, ResultW;
   logic          MemWriteM;
   logic [CW-1:0] StallCount, FlushCount;

   ctrl_pipe #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .CLK(CLK), .Reset(Reset),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .FowardAE(FowardAE), .FowardBE(FowardBE), .InstrF(InstrF),
      .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
      .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
      .PCSrcD(PCSrcD), .BranchD(BranchD),
      .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
      .ALUResultE(ALUResultE), .CondExE(CondExE), .ReadDataM(ReadDataM),
      .PCF(PCF), .PCPlus4D(PCPlus4D), .InstrD(InstrD),
      .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .MemToRegE(MemToRegE), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .BranchTakenE(BranchTakenE),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .ExtImmE(ExtImmE),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ResultW(ResultW),
      .MemWriteM(MemWriteM), .StallCount(StallCount), .FlushCount(FlushCount)
   );

   always #5 CLK = ~CLK;

   localparam int S_PCF = 0, S_INSTRD = 1, S_PCP4D = 2, S_SRCA = 3, S_SRCB = 4,
                  S_M2RE = 5, S_WA3E = 6, S_RWM = 7, S_MWM = 8, S_WA3M = 9,
                  S_PCSRCW = 10, S_BTE = 11, S_RESW = 12, S_STALLC = 13,
                  S_FLUSHC = 14, S_WA3W = 15, S_PCSRCE = 16;

   typedef struct {
      int          id;
      logic [31:0] v;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

`ifdef CTRL_PIPE_PERF_EN
   localparam logic [31:0] EXP_STALL_SAT = 32'd3;
   localparam logic [31:0] EXP_FLUSH_ONE = 32'd1;
`else
   localparam logic [31:0] EXP_STALL_SAT = 32'd0;
   localparam logic [31:0] EXP_FLUSH_ONE = 32'd0;
`endif

   function automatic logic [31:0] sig(input int id);
      case (id)
         S_PCF:    return PCF;
         S_INSTRD: return InstrD;
         S_PCP4D:  return PCPlus4D;
         S_SRCA:   return SrcAE;
         S_SRCB:   return SrcBE;
         S_M2RE:   return 32'(MemToRegE);
         S_WA3E:   return 32'(WA3E);
         S_RWM:    return 32'(RegWriteM);
         S_MWM:    return 32'(MemWriteM);
         S_WA3M:   return 32'(WA3M);
         S_PCSRCW: return 32'(PCSrcW);
         S_BTE:    return 32'(BranchTakenE);
         S_RESW:   return ResultW;
         S_STALLC: return 32'(StallCount);
         S_FLUSHC: return 32'(FlushCount);
         S_WA3W:   return 32'(WA3W);
         S_PCSRCE: return 32'(PCSrcE);
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic string sig_name(input int id);
      case (id)
         S_PCF:    return "PCF";
         S_INSTRD: return "InstrD";
         S_PCP4D:  return "PCPlus4D";
         S_SRCA:   return "SrcAE";
         S_SRCB:   return "SrcBE";
         S_M2RE:   return "MemToRegE";
         S_WA3E:   return "WA3E";
         S_RWM:    return "RegWriteM";
         S_MWM:    return "MemWriteM";
         S_WA3M:   return "WA3M";
         S_PCSRCW: return "PCSrcW";
         S_BTE:    return "BranchTakenE";
         S_RESW:   return "ResultW";
         S_STALLC: return "StallCount";
         S_FLUSHC: return "FlushCount";
         S_WA3W:   return "WA3W";
         S_PCSRCE: return "PCSrcE";
         default:  return "unknown";
      endcase
   endfunction

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: at each falling edge, compare every entry that is due this cycle.
   always @(negedge CLK) begin : monitor
      exp_t keep[$];
      logic [31:0] act;
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].due == cyc) begin
            act = sig(sb[i].id);
            checks++;
            if (act !== sb[i].v) begin
               errors++;
               $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                        sig_name(sb[i].id), act, sb[i].v, cyc);
            end
         end else if (sb[i].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never sampled", sig_name(sb[i].id), sb[i].due);
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   end

   task automatic expect_at(input int id, input logic [31:0] v, input int k);
      exp_t e;
      e.id  = id;
      e.v   = v;
      e.due = cyc + k;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
      FowardAE = 2'b00; FowardBE = 2'b00; InstrF = '0;
      RA1D = '0; RA2D = '0; WA3D = '0;
      RegWriteD = 0; MemToRegD = 0; MemWriteD = 0; PCSrcD = 0; BranchD = 0;
      RD1D = '0; RD2D = '0; ExtImmD = '0; ALUResultE = '0; ReadDataM = '0;
      CondExE = 1;
   endtask

   initial begin
      // Reset held for two cycles with busy inputs
      Reset = 0;
      StallF = 1; StallD = 1; FlushD = 0; FlushE = 0;
      FowardAE = 2'b10; FowardBE = 2'b01; InstrF = 32'hCAFE_F00D;
      RA1D = 5'd3; RA2D = 5'd4; WA3D = 5'd5;
      RegWriteD = 1; MemToRegD = 1; MemWriteD = 1; PCSrcD = 1; BranchD = 1;
      RD1D = 32'h1111; RD2D = 32'h2222; ExtImmD = 32'h3333;
      ALUResultE = 32'h4444; CondExE = 1; ReadDataM = 32'h5555;
      step(); step();
      expect_at(S_PCF, 32'h0, 0);
      expect_at(S_INSTRD, 32'h0, 0);
      expect_at(S_PCP4D, 32'h0, 0);
      expect_at(S_SRCA, 32'h0, 0);
      expect_at(S_RESW, 32'h0, 0);
      expect_at(S_WA3W, 32'h0, 0);
      expect_at(S_MWM, 32'h0, 0);
      expect_at(S_BTE, 32'h0, 0);
      expect_at(S_STALLC, 32'h0, 0);

      // Release: PC steps 0, 4, 8
      clear_inputs();
      Reset = 1;
      expect_at(S_PCF, 32'h4, 1);
      expect_at(S_PCF, 32'h8, 2);
      step(); step();

      // EX->EX forwarding from ALUOutM, then register file, then ResultW on B
      RD1D = 32'h5; ALUResultE = 32'h11; InstrF = 32'h1234;
      step();
      FowardAE = 2'b10;
      expect_at(S_SRCA, 32'h11, 0);
      expect_at(S_INSTRD, 32'h1234, 0);
      expect_at(S_PCP4D, 32'hC, 0);
      step();
      FowardAE = 2'b00; FowardBE = 2'b01;
      expect_at(S_SRCA, 32'h5, 0);
      expect_at(S_SRCB, 32'h11, 0);
      step();
      FowardBE = 2'b00; RD1D = '0; ALUResultE = '0;

      // Load-use bubble
      RegWriteD = 1; MemToRegD = 1; WA3D = 5'd7; InstrF = 32'h5678;
      step();
      expect_at(S_M2RE, 32'h1, 0);
      expect_at(S_WA3E, 32'h7, 0);
      StallF = 1; StallD = 1; FlushE = 1; InstrF = 32'h9999;
      expect_at(S_PCF, 32'h18, 1);
      expect_at(S_INSTRD, 32'h5678, 1);
      expect_at(S_M2RE, 32'h0, 1);
      expect_at(S_WA3E, 32'h0, 1);
      expect_at(S_RWM, 32'h1, 1);
      step();
      StallF = 0; StallD = 0; FlushE = 0;
      RegWriteD = 0; MemToRegD = 0; WA3D = '0;
      expect_at(S_RWM, 32'h0, 1);
      step();

      // Condition fails in Execute: writes suppressed, tag still advances
      RegWriteD = 1; MemWriteD = 1; WA3D = 5'd9;
      step();
      CondExE = 0; RegWriteD = 0; MemWriteD = 0; WA3D = '0;
      expect_at(S_RWM, 32'h0, 1);
      expect_at(S_MWM, 32'h0, 1);
      expect_at(S_WA3M, 32'h9, 1);
      step();
      CondExE = 1;

      // Load result selection in Writeback
      MemToRegD = 1; ReadDataM = 32'hABCD; ALUResultE = 32'h1;
      expect_at(S_RESW, 32'hABCD, 3);
      expect_at(S_RESW, 32'h1, 4);
      step();
      MemToRegD = 0;
      step(); step(); step();
      ALUResultE = '0; ReadDataM = '0;

      // PCSrcW and BranchTakenE together, then branch alone
      PCSrcD = 1;
      step();
      PCSrcD = 0; ALUResultE = 32'h80;
      expect_at(S_PCSRCE, 32'h1, 0);
      step();
      ALUResultE = '0; BranchD = 1;
      step();
      ALUResultE = 32'h40;
      expect_at(S_BTE, 32'h1, 0);
      expect_at(S_PCSRCW, 32'h1, 0);
      expect_at(S_RESW, 32'h80, 0);
      expect_at(S_PCF, 32'h80, 1);
      step();
      BranchD = 0;
      expect_at(S_BTE, 32'h1, 0);
      expect_at(S_PCSRCW, 32'h0, 0);
      expect_at(S_PCF, 32'h40, 1);
      step();
      ALUResultE = '0;

      // FlushD beats StallD
      FlushD = 1; StallD = 1; InstrF = 32'hAAAA;
      expect_at(S_INSTRD, 32'h0, 1);
      expect_at(S_PCP4D, 32'h0, 1);
      step();
      FlushD = 0; StallD = 0;

      // Counter saturation
      StallD = 1;
      expect_at(S_STALLC, EXP_STALL_SAT, 5);
      expect_at(S_FLUSHC, EXP_FLUSH_ONE, 5);
      repeat (5) step();
      StallD = 0;

      // Reset mid-operation
      RegWriteD = 1; WA3D = 5'd12;
      step();
      Reset = 0;
      expect_at(S_PCF, 32'h0, 1);
      expect_at(S_INSTRD, 32'h0, 1);
      expect_at(S_WA3M, 32'h0, 1);
      expect_at(S_STALLC, 32'h0, 1);
      step();
      Reset = 1; RegWriteD = 0; WA3D = '0;
      step(); step();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
